// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers and parameter legality check for the parametrised FIFO
package fifo_pkg;
  function automatic int clog2_depth(input int depth);
    int r;
    r = 0;
    while ((1 << r) < depth) r++;
    return r;
  endfunction
  localparam int DEF_DEPTH = 16;
  localparam int ADDR_W = clog2_depth(DEF_DEPTH);
  localparam int CNT_W = ADDR_W + 1;
  function automatic bit params_ok(input int depth, input int af, input int ae);
    return depth >= 4 && (depth & (depth - 1)) == 0 && af >= 0 && af <= depth && ae >= 0 && ae <= depth;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port RAM, synchronous write, registered read with enable
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW = clog2_depth(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end
  // only the output register is reset; the array keeps stale words
  always_ff @(posedge clock) begin
    if (!reset_n) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised synchronous FIFO with registered read, count, almost flags and error pulses
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);
  localparam int AW = clog2_depth(DEPTH);
  localparam int CW = AW + 1;
  if (!params_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("sync_fifo_param: illegal DEPTH/AF_LEVEL/AE_LEVEL");
  end
  logic [CW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, cnt_nxt;
  logic rd_acc, wr_acc;
  always_comb begin
    rd_acc = rd_en & ~empty;
    wr_acc = wr_en & (~full | rd_acc);
    wr_nxt = wr_ptr + CW'(wr_acc);
    rd_nxt = rd_ptr + CW'(rd_acc);
    cnt_nxt = count + CW'(wr_acc) - CW'(rd_acc);
  end
  // flags come from next-state pointers so they settle on the causing edge
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      almost_full <= 1'b0;
      almost_empty <= 1'b1;
      overflow <= 1'b0;
      underflow <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      count <= cnt_nxt;
      full <= (wr_nxt ^ rd_nxt) == {1'b1, {AW{1'b0}}};
      empty <= wr_nxt == rd_nxt;
      almost_full <= cnt_nxt >= CW'(AF_LEVEL);
      almost_empty <= cnt_nxt <= CW'(AE_LEVEL);
      overflow <= wr_en & ~wr_acc;
      underflow <= rd_en & empty;
      rd_valid <= rd_acc;
    end
  end
  fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed stimulus with a queue-based reference model and literal checks
module tb_sync_fifo_param;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic rd_en = 1'b0;
  logic [7:0] rd_data;
  logic rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;
  logic [7:0] q[$];
  logic [7:0] m_rd_data;
  bit m_rd_valid, m_ov, m_un;

  always #5 clock = ~clock;

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a queue of stored words, evaluated on each rising edge
  always @(posedge clock) begin
    bit rd_ok, wr_ok;
    if (!reset_n) begin
      q.delete();
      m_rd_data = 8'h00;
      m_rd_valid = 1'b0;
      m_ov = 1'b0;
      m_un = 1'b0;
      armed = 1'b1;
    end else begin
      rd_ok = rd_en && q.size() > 0;
      wr_ok = wr_en && (q.size() < 16 || rd_ok);
      m_un = rd_en && q.size() == 0;
      m_ov = wr_en && !wr_ok;
      m_rd_valid = rd_ok;
      if (rd_ok) m_rd_data = q.pop_front();
      if (wr_ok) q.push_back(wr_data);
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      chk("m_count", count, q.size());
      chk("m_empty", empty, q.size() == 0);
      chk("m_full", full, q.size() == 16);
      chk("m_almost_full", almost_full, q.size() >= 14);
      chk("m_almost_empty", almost_empty, q.size() <= 2);
      chk("m_overflow", overflow, m_ov);
      chk("m_underflow", underflow, m_un);
      chk("m_rd_valid", rd_valid, m_rd_valid);
      chk("m_rd_data", rd_data, m_rd_data);
    end
  end

  task automatic cyc(input bit w, input logic [7:0] d, input bit r);
    wr_en = w;
    wr_data = d;
    rd_en = r;
    @(negedge clock);
  endtask

  initial begin
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);
    reset_n = 1'b1;
    cyc(0, 8'h00, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_almost_empty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_errors", {overflow, underflow}, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 8'(i), 0);
      if (i == 12) chk("af_at13", almost_full, 0);
      if (i == 13) chk("af_at14", almost_full, 1);
      if (i == 14) chk("not_full_at15", full, 0);
    end
    chk("full_at16", full, 1);
    chk("count_16", count, 16);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 8'h00, 1);
      chk("seq_rd_valid", rd_valid, 1);
      chk("seq_rd_data", rd_data, i);
    end
    cyc(0, 8'h00, 0);
    chk("drained_empty", empty, 1);
    chk("drained_rd_valid", rd_valid, 0);
    chk("hold_rd_data", rd_data, 8'h0F);
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h10 + i), 0);
    cyc(1, 8'hAA, 0);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", count, 16);
    cyc(0, 8'h00, 0);
    chk("ovf_once", overflow, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 8'h00, 1);
      chk("ovf_rd_data", rd_data, 8'h10 + i);
    end
    cyc(0, 8'h00, 0);
    chk("no_aa_empty", empty, 1);
    cyc(0, 8'h00, 1);
    chk("unf_pulse", underflow, 1);
    chk("unf_rd_valid", rd_valid, 0);
    chk("unf_rd_data", rd_data, 8'h1F);
    cyc(0, 8'h00, 0);
    chk("unf_once", underflow, 0);
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h20 + i), 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 8'(8'h40 + i), 1);
      chk("rw_count", count, 16);
      chk("rw_no_ovf", overflow, 0);
      chk("rw_rd_data", rd_data, i < 16 ? 8'h20 + i : 8'h40 + i - 16);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(0, 8'h00, 1);
      chk("wrap_rd_data", rd_data, 8'h44 + i);
    end
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h60 + i), 0);
    chk("pre_rst_count", count, 5);
    reset_n = 1'b0;
    cyc(0, 8'h00, 0);
    reset_n = 1'b1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    cyc(0, 8'h00, 1);
    chk("mid_rst_unf", underflow, 1);
    chk("mid_rst_rd_valid", rd_valid, 0);
    cyc(0, 8'h00, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
